// File: rtl/div_pkg.sv
// div_pkg -- shared types and constants for the div_sequencer slice.
//   div_state_t     : sequencer state encoding (IDLE, ITER, FIX, DONE)
//   DIV_WIDTH       : default operand width
//   DIV_COUNT_W     : iteration counter width for the default operand width
//   count_width()   : iteration counter width for any operand width
//   DIV_ZERO_Q_BIT  : fill bit of the divide-by-zero quotient (all ones)
// Optional feature macro used by the slice: DIV_SIGNED_EN.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam int DIV_WIDTH = 32;

  // Counter must hold 0..WIDTH-1 with a spare bit so WIDTH itself is representable.
  function automatic int count_width(input int width);
    return $clog2(width) + 1;
  endfunction

  localparam int DIV_COUNT_W = $clog2(DIV_WIDTH) + 1;

  localparam logic DIV_ZERO_Q_BIT = 1'b1;

endpackage

// File: rtl/div_sequencer_if.sv
// div_sequencer_if -- request/result handshake bundle between the execute
// stage (master) and the divide sequencer (slave).
//   req_valid/req_ready : operand pair handshake, dividend/divisor sampled on accept
//   res_valid/res_ready : result handshake, quotient/remainder/div_zero held while valid
interface div_sequencer_if #(
  parameter int WIDTH = 32
);

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;

  modport master (
    output req_valid, dividend, divisor, res_ready,
    input  req_ready, res_valid, quotient, remainder, div_zero
  );

  modport slave (
    input  req_valid, dividend, divisor, res_ready,
    output req_ready, res_valid, quotient, remainder, div_zero
  );

endinterface

// File: rtl/div_step.sv
// div_step -- one combinational non-restoring division iteration.
//   a      : partial remainder, WIDTH+1 bits, a[WIDTH] is the sign
//   q      : partial quotient / remaining dividend bits
//   m      : divisor magnitude
//   a_next : partial remainder after shift and add/subtract
//   q_next : quotient after shift with the new quotient bit in bit 0
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   a_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] a_sh;
  logic [WIDTH:0] m_ext;

  always_comb begin
    a_sh   = {a[WIDTH-1:0], q[WIDTH-1]};
    m_ext  = {1'b0, m};
    // Sign of the pre-shift remainder picks subtract (non-negative) or add back.
    a_next = a[WIDTH] ? (a_sh + m_ext) : (a_sh - m_ext);
    q_next = {q[WIDTH-2:0], ~a_next[WIDTH]};
  end

endmodule

// File: rtl/div_sequencer.sv
// div_sequencer -- multi-cycle non-restoring divider controller, one
// iteration per clock through a single div_step instance.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   flush : synchronous abort, drops any operation in flight
//   bus   : div_sequencer_if slave (request in, result out)
// Build option: define DIV_SIGNED_EN for two's complement operands.
//
//   state | meaning
//   IDLE  | waiting for an operand pair, req_ready high unless flushing
//   ITER  | one shift/add-subtract step per clock, WIDTH steps
//   FIX   | final remainder correction, result registers loaded
//   DONE  | result presented, held until res_ready
module div_sequencer
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic            clk,
  input logic            rst_n,
  input logic            flush,
  div_sequencer_if.slave bus
);

  localparam int CW = count_width(WIDTH);

  div_state_t       state, state_next;
  logic [WIDTH:0]   a_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] m_r;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             div_zero_r;

  logic             accept;
  logic             divisor_zero;
  logic             last_step;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   a_step;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH:0]   a_fix;
  logic [WIDTH-1:0] q_res;
  logic [WIDTH-1:0] r_res;

`ifdef DIV_SIGNED_EN
  logic neg_q_r;
  logic neg_r_r;
`endif

  assign accept       = bus.req_valid && bus.req_ready;
  assign divisor_zero = (bus.divisor == '0);
  assign last_step    = (count_r == CW'(WIDTH - 1));

`ifdef DIV_SIGNED_EN
  // MIN's magnitude is 2^(WIDTH-1), which still fits as an unsigned value.
  assign dvd_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
  assign dvs_mag = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
`else
  assign dvd_mag = bus.dividend;
  assign dvs_mag = bus.divisor;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .a      (a_r),
    .q      (q_r),
    .m      (m_r),
    .a_next (a_step),
    .q_next (q_step)
  );

  always_comb begin
    a_fix = a_r[WIDTH] ? (a_r + {1'b0, m_r}) : a_r;
    q_res = q_r;
    r_res = a_fix[WIDTH-1:0];
`ifdef DIV_SIGNED_EN
    if (neg_q_r) q_res = -q_r;
    if (neg_r_r) r_res = -a_fix[WIDTH-1:0];
`endif
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // next-state logic
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (accept) state_next = divisor_zero ? DONE : ITER;
        ITER: if (last_step) state_next = FIX;
        FIX:  state_next = DONE;
        DONE: if (bus.res_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // outputs
  always_comb begin
    bus.req_ready = (state == IDLE) && !flush;
    bus.res_valid = (state == DONE);
    bus.quotient  = quotient_r;
    bus.remainder = remainder_r;
    bus.div_zero  = div_zero_r;
  end

  // Datapath and result registers. Result registers only move on the
  // transitions into DONE, so a flushed or consumed result keeps its value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r         <= '0;
      q_r         <= '0;
      m_r         <= '0;
      count_r     <= '0;
      quotient_r  <= '0;
      remainder_r <= '0;
      div_zero_r  <= 1'b0;
    end else if (accept) begin
      a_r     <= '0;
      q_r     <= dvd_mag;
      m_r     <= dvs_mag;
      count_r <= '0;
      if (divisor_zero) begin
        quotient_r  <= {WIDTH{DIV_ZERO_Q_BIT}};
        remainder_r <= bus.dividend;
        div_zero_r  <= 1'b1;
      end
    end else if (!flush && state == ITER) begin
      a_r     <= a_step;
      q_r     <= q_step;
      count_r <= count_r + 1'b1;
    end else if (!flush && state == FIX) begin
      quotient_r  <= q_res;
      remainder_r <= r_res;
      div_zero_r  <= 1'b0;
    end
  end

`ifdef DIV_SIGNED_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
    end else if (accept) begin
      neg_q_r <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
      neg_r_r <= bus.dividend[WIDTH-1];
    end
  end
`endif

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle controller that runs a WIDTH-bit non-restoring division one iteration per clock. It sits between the CPU execute stage and a single combinational iteration stage, which it instantiates. It accepts an operand pair over a valid/ready handshake, sequences WIDTH add/subtract-shift steps, applies the final remainder correction, and holds the result until the consumer takes it. It also handles divide-by-zero and an optional signed mode.

## Interface
- WIDTH, 32, operand/result width; legal values ≥ 2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  operand pair offered.
- req_ready  out  1  sequencer can accept; equals (state==IDLE) && !flush.
- dividend  in  WIDTH  numerator, sampled on accept.
- divisor  in  WIDTH  denominator, sampled on accept.
- flush  in  1  synchronous abort; discards any operation in flight.
- res_valid  out  1  quotient/remainder/div_zero valid.
- res_ready  in  1  consumer takes the result.
- quotient  out  WIDTH  result quotient.
- remainder  out  WIDTH  result remainder.
- div_zero  out  1  divisor was zero.

## Operation
- States: IDLE, ITER, FIX, DONE.
- IDLE: on req_valid && req_ready:
  - Latch |divisor| into M.
  - Load A=0 (WIDTH+1 bits, sign bit A[WIDTH]) and Q=|dividend|; count=0.
  - If divisor==0, go to DONE with quotient=all ones, remainder=dividend, div_zero=1. Otherwise go to ITER.
- ITER: each cycle shift {A,Q} left by 1.
  - If A[WIDTH] was 0 before the shift, A=A−M; otherwise A=A+M.
  - Q[0]=~A_new[WIDTH].
  - count increments; after the WIDTH-th step, go to FIX.
- FIX: if A[WIDTH]==1, A=A+M. Register quotient=Q and remainder=A[WIDTH-1:0], then go to DONE.
- DONE: res_valid=1 and outputs are stable. On res_ready, go to IDLE and leave the outputs holding their last values.
- flush in any state: go to IDLE on the next edge, clear res_valid, and produce no result. flush together with req_valid in IDLE: the request is not accepted.
- Outputs change only on the FIX→DONE or IDLE→DONE (zero) transitions.

## Timing
- Reset values: state=IDLE, req_ready=1, res_valid=0, quotient=0, remainder=0, div_zero=0, count=0.
- Normal latency: res_valid rises WIDTH+1 edges after the accept edge (33 for WIDTH=32).
- Divide-by-zero latency: res_valid rises 1 edge after accept.
- Throughput: the next accept is possible on the edge after the res_valid && res_ready handshake. There is no overlap between operations.
- res_valid stays high with the result stable while res_ready=0, indefinitely.
- An asynchronous reset mid-operation returns immediately to the reset values. The partial result is lost.

## Configuration
- DIV_SIGNED_EN defined:
  - Operands are two's complement; magnitudes are taken on accept, and the operand signs are latched.
  - In FIX, quotient is negated if the signs differ, and remainder takes the dividend's sign.
  - MIN/−1 yields quotient=MIN, remainder=0.
  - Divide-by-zero behaves as above (quotient all ones, remainder=dividend).
  - Latency is unchanged.
- DIV_SIGNED_EN undefined: operands are unsigned, with no sign logic or sign registers.

## Structure
- Package div_pkg holds:
  - the state enum div_state_t (IDLE, ITER, FIX, DONE);
  - the localparam for count width, $clog2(WIDTH)+1;
  - the divide-by-zero quotient constant (all ones).
- Sub-module div_step is combinational and does one iteration. Inputs: A, Q, M. Outputs: next A and next Q. div_sequencer instantiates it once and owns all registers.

## Test plan
- Unsigned, WIDTH=32: 100/7 → quotient=14, remainder=2; res_valid exactly 33 edges after accept. 0xFFFFFFFF/1 → 0xFFFFFFFF, remainder 0.
- Divide-by-zero: 55/0 → quotient=0xFFFFFFFF, remainder=55, div_zero=1, res_valid one edge after accept.
- Backpressure: hold res_ready=0 for 10 cycles after res_valid. Outputs and res_valid must stay stable and req_ready must stay 0. Then res_ready=1 gives IDLE on the next edge.
- flush at ITER count=5 → IDLE next edge with res_valid never asserted. A new 9/4 request is then accepted and gives quotient 2, remainder 1.
- rst_n low mid-ITER → all outputs return to their reset values immediately. req_ready=1 after rst_n deasserts.
- DIV_SIGNED_EN: −7/2 → −3 r −1; 7/−2 → −3 r 1; 0x80000000/−1 → 0x80000000 r 0.
